multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Parametrised multicycle control unit for the 16-bit datapath: fetch/decode/execute FSM driving PC, IR, register file, ALU and data memory.
//  Adds variable-latency data-memory handshake with timeout, JMP/JZ control flow, logic ALU ops and a resumable HALT.
//  Sits between instruction register/PC and the datapath. Outputs are combinational from state + IR.
// PARAMETERS
//  DA_W       8   data memory address width (1..8); D_ADDR = low DA_W bits of the IR address field
//  RA_W       4   register address width (1..4); RF addresses = low RA_W bits of each 4-bit IR field
//  PC_W       8   program counter width (1..12); jump targets = IR[PC_W-1:0]
//  WAIT_LIMIT 15  max cycles waiting for D_RDY before the FSM enters ERROR (>=1)
// PORTS
//  Clock      in  1      clock, rising edge
//  Reset      in  1      synchronous, active-high
//  IR         in  16     current instruction register contents
//  D_RDY      in  1      data memory done (read data valid / write accepted)
//  A_ZERO     in  1      register file A-port read data == 0
//  Resume     in  1      leave HALT
//  PC_CLR     out 1      clear PC
//  PC_IC      out 1      increment PC
//  PC_LD      out 1      load PC from PC_TGT
//  PC_TGT     out PC_W   jump/branch target
//  IR_LD      out 1      load IR from instruction memory
//  D_ADDR     out DA_W   data memory address
//  D_RD       out 1      data memory read request
//  D_WR       out 1      data memory write request
//  RF_S       out 1      RF write mux: 1 = memory, 0 = ALU
//  RF_W_EN    out 1      RF write enable
//  RF_A_ADDR  out RA_W   RF A read address
//  RF_B_ADDR  out RA_W   RF B read address
//  RF_W_ADDR  out RA_W   RF write address
//  ALU_S      out 4      ALU function select
//  Halted     out 1      high in HALT
//  Error      out 1      high in ERROR
//  State      out 4      current state encoding (debug)
// BEHAVIOUR
//  Opcode IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JMP, 7 JZ, 8 AND, 9 OR, A XOR; B-F illegal.
//  ALU_S: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
//  Unlisted outputs are 0 in every state. On Reset: state=INIT, wait counter=0; outputs take INIT values.
//  INIT(0): PC_CLR=1 -> FETCH.
//  FETCH(1): IR_LD=1 -> DECODE.
//  DECODE(2): PC_IC=1; dispatch by opcode; illegal opcode -> ERROR.
//  LOAD_A(3): D_RD=1, D_ADDR=IR[11:4], RF_S=1, RF_W_ADDR=IR[3:0]; counter increments each cycle while D_RDY=0.
//   On D_RDY=1 -> LOAD_B. On counter==WAIT_LIMIT with D_RDY=0 -> ERROR.
//  LOAD_B(4): RF_S=1, RF_W_EN=1, RF_W_ADDR=IR[3:0] -> FETCH.
//  STORE(5): D_WR=1, D_ADDR=IR[7:0], RF_A_ADDR=IR[11:8]; same wait/timeout rule as LOAD_A. On D_RDY=1 -> FETCH.
//  ALU(6), shared by ADD/SUB/AND/OR/XOR: RF_A=IR[11:8], RF_B=IR[7:4], RF_W=IR[3:0], RF_W_EN=1, RF_S=0 -> FETCH.
//  JMP(7): PC_LD=1, PC_TGT=IR[PC_W-1:0] -> FETCH.
//  JZ(8): RF_A_ADDR=IR[11:8], PC_TGT=IR[PC_W-1:0]. PC_LD=A_ZERO. -> FETCH.
//   The PC_IC from DECODE has already committed; a taken branch overrides it.
//  NOOP(9): -> FETCH.
//  HALT(A): Halted=1; stays while Resume=0; Resume=1 -> FETCH.
//  ERROR(B): Error=1; absorbing, left only by Reset.
//  Wait counter: cleared on entry to LOAD_A/STORE and on every exit from them. Saturates at WAIT_LIMIT.
//   D_RDY=1 on the same cycle the counter hits WAIT_LIMIT counts as success.
//  Reset has priority over every state, including mid-wait, HALT and ERROR; it takes effect on the next edge.
//  PC_CLR, PC_IC and PC_LD are never asserted in the same cycle.
//  Unused State codes C-F -> INIT.
// TESTING
//  1. Reset, IR=0x3123 (ADD) -> PC_CLR@INIT, IR_LD@FETCH, PC_IC@DECODE; ALU cycle: RF_A=1, RF_B=2, RF_W=3, ALU_S=0, RF_W_EN=1.
//  2. IR=0x2A57 (LOAD), D_RDY held low 3 cycles -> D_RD/D_ADDR=0xA5 for 4 cycles, then LOAD_B: RF_W_EN=1, RF_W=7, RF_S=1.
//  3. IR=0x1420 (STORE), D_RDY never -> D_WR held WAIT_LIMIT+1 cycles, then Error=1 persists until Reset.
//  4. IR=0x7340 (JZ), A_ZERO=1 -> PC_LD=1, PC_TGT=0x40. Repeat with A_ZERO=0 -> PC_LD=0.
//  5. IR=0x5000 (HALT) -> Halted=1 for 10 cycles with Resume=0; Resume pulse -> next state FETCH.
//  6. IR=0xF000 -> ERROR. Assert Reset mid LOAD_A wait -> state INIT next edge, counter=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute control unit for the 16-bit datapath.
// Datapath controls are decoded combinationally from the current state and IR.
module multicycle_ctrl #(
    parameter int DA_W       = 8,
    parameter int RA_W       = 4,
    parameter int PC_W       = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     IR,
    input  logic            D_RDY,
    input  logic            A_ZERO,
    input  logic            Resume,
    output logic            PC_CLR,
    output logic            PC_IC,
    output logic            PC_LD,
    output logic [PC_W-1:0] PC_TGT,
    output logic            IR_LD,
    output logic [DA_W-1:0] D_ADDR,
    output logic            D_RD,
    output logic            D_WR,
    output logic            RF_S,
    output logic            RF_W_EN,
    output logic [RA_W-1:0] RF_A_ADDR,
    output logic [RA_W-1:0] RF_B_ADDR,
    output logic [RA_W-1:0] RF_W_ADDR,
    output logic [3:0]      ALU_S,
    output logic            Halted,
    output logic            Error,
    output logic [3:0]      State
);

    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ALU    = 4'd6,
        S_JMP    = 4'd7,
        S_JZ     = 4'd8,
        S_NOOP   = 4'd9,
        S_HALT   = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic [3:0] opcode;
    logic [3:0] fld_a;
    logic [3:0] fld_b;
    logic [3:0] fld_w;
    logic [7:0] ld_addr;
    logic [7:0] st_addr;

    assign opcode  = IR[15:12];
    assign fld_a   = IR[11:8];
    assign fld_b   = IR[7:4];
    assign fld_w   = IR[3:0];
    assign ld_addr = IR[11:4];
    assign st_addr = IR[7:0];

    // Memory waits share one counter; it is zeroed on entry and on every exit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_INIT;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    wait_cnt <= '0;
                    case (opcode)
                        OP_NOOP:  state <= S_NOOP;
                        OP_STORE: state <= S_STORE;
                        OP_LOAD:  state <= S_LOAD_A;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_ALU;
                        OP_HALT:  state <= S_HALT;
                        OP_JMP:   state <= S_JMP;
                        OP_JZ:    state <= S_JZ;
                        default:  state <= S_ERROR;
                    endcase
                end
                S_LOAD_A, S_STORE: begin
                    if (D_RDY) begin
                        wait_cnt <= '0;
                        if (state == S_LOAD_A) state <= S_LOAD_B;
                        else                   state <= S_FETCH;
                    end else if (wait_cnt == CNT_MAX) begin
                        wait_cnt <= '0;
                        state    <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_LOAD_B, S_ALU, S_JMP, S_JZ, S_NOOP: state <= S_FETCH;
                S_HALT:   if (Resume) state <= S_FETCH;
                S_ERROR:  state <= S_ERROR;
                default:  state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        PC_CLR    = 1'b0;
        PC_IC     = 1'b0;
        PC_LD     = 1'b0;
        PC_TGT    = '0;
        IR_LD     = 1'b0;
        D_ADDR    = '0;
        D_RD      = 1'b0;
        D_WR      = 1'b0;
        RF_S      = 1'b0;
        RF_W_EN   = 1'b0;
        RF_A_ADDR = '0;
        RF_B_ADDR = '0;
        RF_W_ADDR = '0;
        ALU_S     = 4'd0;
        Halted    = 1'b0;
        Error     = 1'b0;
        State     = state;
        case (state)
            S_INIT:   PC_CLR = 1'b1;
            S_FETCH:  IR_LD  = 1'b1;
            S_DECODE: PC_IC  = 1'b1;
            S_LOAD_A: begin
                D_RD      = 1'b1;
                D_ADDR    = ld_addr[DA_W-1:0];
                RF_S      = 1'b1;
                RF_W_ADDR = fld_w[RA_W-1:0];
            end
            S_LOAD_B: begin
                RF_S      = 1'b1;
                RF_W_EN   = 1'b1;
                RF_W_ADDR = fld_w[RA_W-1:0];
            end
            S_STORE: begin
                D_WR      = 1'b1;
                D_ADDR    = st_addr[DA_W-1:0];
                RF_A_ADDR = fld_a[RA_W-1:0];
            end
            S_ALU: begin
                RF_A_ADDR = fld_a[RA_W-1:0];
                RF_B_ADDR = fld_b[RA_W-1:0];
                RF_W_ADDR = fld_w[RA_W-1:0];
                RF_W_EN   = 1'b1;
                case (opcode)
                    OP_SUB:  ALU_S = 4'd1;
                    OP_AND:  ALU_S = 4'd2;
                    OP_OR:   ALU_S = 4'd3;
                    OP_XOR:  ALU_S = 4'd4;
                    default: ALU_S = 4'd0;
                endcase
            end
            S_JMP: begin
                PC_LD  = 1'b1;
                PC_TGT = IR[PC_W-1:0];
            end
            // PC_IC already committed in DECODE; a taken branch overwrites it.
            S_JZ: begin
                RF_A_ADDR = fld_a[RA_W-1:0];
                PC_TGT    = IR[PC_W-1:0];
                PC_LD     = A_ZERO;
            end
            S_HALT:   Halted = 1'b1;
            S_ERROR:  Error  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: an instruction-level model queues the
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    localparam int WL = 15;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IR = 16'h0;
    logic        D_RDY = 1'b0;
    logic        A_ZERO = 1'b0;
    logic        Resume = 1'b0;

    logic       PC_CLR, PC_IC, PC_LD, IR_LD, D_RD, D_WR, RF_S, RF_W_EN, Halted, Error;
    logic [7:0] PC_TGT, D_ADDR;
    logic [3:0] RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, State;

    multicycle_ctrl #(.DA_W(8), .RA_W(4), .PC_W(8), .WAIT_LIMIT(WL)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .D_RDY(D_RDY), .A_ZERO(A_ZERO),
        .Resume(Resume), .PC_CLR(PC_CLR), .PC_IC(PC_IC), .PC_LD(PC_LD),
        .PC_TGT(PC_TGT), .IR_LD(IR_LD), .D_ADDR(D_ADDR), .D_RD(D_RD), .D_WR(D_WR),
        .RF_S(RF_S), .RF_W_EN(RF_W_EN), .RF_A_ADDR(RF_A_ADDR),
        .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR), .ALU_S(ALU_S),
        .Halted(Halted), .Error(Error), .State(State)
    );

    initial forever #5 Clock = ~Clock;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_ic;
        logic       pc_ld;
        logic [7:0] pc_tgt;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [3:0] rf_a;
        logic [3:0] rf_b;
        logic [3:0] rf_w;
        logic [3:0] alu_s;
        logic       halted;
        logic       error;
        logic [3:0] state;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    // Monitor: one expected record per checked cycle.
    always @(negedge Clock) begin
        exp_t  e;
        exp_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = exp_t'({PC_CLR, PC_IC, PC_LD, PC_TGT, IR_LD, D_ADDR, D_RD, D_WR,
                        RF_S, RF_W_EN, RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S,
                        Halted, Error, State});
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s t=%0t state got=%0d want=%0d outputs got=%h want=%h",
                         t, $time, a.state, e.state, a, e);
            end
        end
    end

    function automatic exp_t base(input int st);
        exp_t e;
        e = '0;
        e.state = 4'(st);
        return e;
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] op);
        case (op)
            4'h4:    return 4'd1;
            4'h8:    return 4'd2;
            4'h9:    return 4'd3;
            4'hA:    return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    task automatic noise();
        D_RDY  = 1'($urandom_range(0, 1));
        A_ZERO = 1'($urandom_range(0, 1));
        Resume = 1'($urandom_range(0, 1));
    endtask

    task automatic step(input exp_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    // Reset cycle; when the current state is known its outputs are checked too.
    task automatic reset_from(input exp_t cur, input bit known);
        exp_t e;
        noise();
        Reset = 1'b1;
        if (known) step(cur, "reset_cycle");
        else begin
            @(posedge Clock);
            #1;
        end
        Reset = 1'b0;
        noise();
        e = base(0);
        e.pc_clr = 1'b1;
        step(e, "init");
    endtask

    task automatic error_tail(input int n);
        exp_t e;
        e = base(11);
        e.error = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise();
            step(e, "error_hold");
        end
        reset_from(e, 1'b1);
    endtask

    task automatic fetch_decode(input logic [15:0] ir);
        exp_t e;
        IR = ir;
        noise();
        e = base(1);
        e.ir_ld = 1'b1;
        step(e, "fetch");
        noise();
        e = base(2);
        e.pc_ic = 1'b1;
        step(e, "decode");
    endtask

    function automatic exp_t wait_exp(input logic [15:0] ir);
        exp_t e;
        if (ir[15:12] == 4'h2) begin
            e = base(3);
            e.d_rd = 1'b1;
            e.d_addr = ir[11:4];
            e.rf_s = 1'b1;
            e.rf_w = ir[3:0];
        end else begin
            e = base(5);
            e.d_wr = 1'b1;
            e.d_addr = ir[7:0];
            e.rf_a = ir[11:8];
        end
        return e;
    endfunction

    // One instruction: lat = unready cycles before D_RDY, hold = HALT cycles
    // before Resume, az = forced A_ZERO for JZ (-1 = random).
    task automatic run_instr(input logic [15:0] ir, input int lat, input int hold, input int az);
        exp_t e;
        logic [3:0] op;
        op = ir[15:12];
        fetch_decode(ir);
        case (op)
            4'h0: begin
                noise();
                step(base(9), "noop");
            end
            4'h1, 4'h2: begin
                for (int k = 0; k <= WL; k++) begin
                    noise();
                    D_RDY = (k == lat);
                    step(wait_exp(ir), (op == 4'h2) ? "load_wait" : "store_wait");
                    if (k == lat) break;
                end
                if (lat > WL) error_tail(3);
                else if (op == 4'h2) begin
                    noise();
                    e = base(4);
                    e.rf_s = 1'b1;
                    e.rf_w_en = 1'b1;
                    e.rf_w = ir[3:0];
                    step(e, "load_wb");
                end
            end
            4'h3, 4'h4, 4'h8, 4'h9, 4'hA: begin
                noise();
                e = base(6);
                e.rf_a = ir[11:8];
                e.rf_b = ir[7:4];
                e.rf_w = ir[3:0];
                e.rf_w_en = 1'b1;
                e.alu_s = alu_of(op);
                step(e, "alu");
            end
            4'h5: begin
                e = base(10);
                e.halted = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    noise();
                    Resume = 1'b0;
                    step(e, "halt_hold");
                end
                noise();
                Resume = 1'b1;
                step(e, "halt_resume");
                Resume = 1'b0;
            end
            4'h6: begin
                noise();
                e = base(7);
                e.pc_ld = 1'b1;
                e.pc_tgt = ir[7:0];
                step(e, "jmp");
            end
            4'h7: begin
                noise();
                if (az >= 0) A_ZERO = az[0];
                e = base(8);
                e.rf_a = ir[11:8];
                e.pc_tgt = ir[7:0];
                e.pc_ld = A_ZERO;
                step(e, "jz");
            end
            default: error_tail(2);
        endcase
    endtask

    initial begin
        int   lat;
        logic [15:0] ir;
        reset_from(base(0), 1'b0);

        run_instr(16'h3123, 0, 0, -1);
        run_instr(16'h2A57, 3, 0, -1);
        run_instr(16'h7340, 0, 0, 1);
        run_instr(16'h7340, 0, 0, 0);
        run_instr(16'h5000, 0, 10, -1);
        run_instr(16'h1420, WL + 1, 0, -1);
        run_instr(16'hF000, 0, 0, -1);
        run_instr(16'h2A57, WL, 0, -1);
        run_instr(16'h1420, WL, 0, -1);
        run_instr(16'h4567, 0, 0, -1);
        run_instr(16'h8ABC, 0, 0, -1);
        run_instr(16'h9DEF, 0, 0, -1);
        run_instr(16'hA135, 0, 0, -1);
        run_instr(16'h60C3, 0, 0, -1);
        run_instr(16'h0000, 0, 0, -1);

        // Reset in the middle of a load wait, then a limit-length wait.
        fetch_decode(16'h2BCD);
        for (int k = 0; k < 5; k++) begin
            noise();
            D_RDY = 1'b0;
            step(wait_exp(16'h2BCD), "load_wait_pre_reset");
        end
        D_RDY = 1'b0;
        reset_from(wait_exp(16'h2BCD), 1'b1);
        run_instr(16'h2BCD, WL, 0, -1);

        for (int n = 0; n < 200; n++) begin
            ir = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lat = int'($urandom_range(0, WL + 2));
            else lat = int'($urandom_range(0, 4));
            run_instr(ir, lat, int'($urandom_range(0, 5)), -1);
        end

        repeat (2) @(posedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
